// File: rtl/rc4_stream_core.sv
// RC4 keystream core: valid/ready key load, INIT/KSA sweep, optional RC4-drop[N]
// discard, then one keystream byte XORed onto each accepted data byte.
module rc4_stream_core #(
  parameter int MAX_KEY_BYTES = 32,
  parameter int DROP_N        = 0,
  parameter int KL_W          = 9
) (
  input  logic            CLK_IN,
  input  logic            RESET_IN,
  input  logic            START_IN,
  input  logic            STOP_IN,
  input  logic [KL_W-1:0] KEY_LEN_IN,
  input  logic            KEY_VALID_IN,
  input  logic [7:0]      KEY_BYTE_IN,
  output logic            KEY_READY_OUT,
  input  logic            DATA_VALID_IN,
  input  logic [7:0]      DATA_IN,
  output logic            DATA_READY_OUT,
  output logic            DATA_VALID_OUT,
  output logic [7:0]      DATA_OUT,
  input  logic            DATA_READY_IN,
  output logic            BUSY_OUT,
  output logic            ERR_OUT
);

  localparam int KI_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY_LOAD, ST_INIT, ST_KSA, ST_DROP, ST_PRGA
  } state_t;

  state_t          state_r, state_n;
  logic [7:0]      s_r [0:255];
  logic [7:0]      key_r [0:(1<<KI_W)-1];
  logic [KL_W-1:0] len_r;
  logic [KI_W-1:0] kidx_r;
  logic [7:0]      i_r, j_r;
  logic [15:0]     drop_r;
  logic            busy_r, key_ready_r, err_r, dvalid_r;
  logic [7:0]      dout_r;

  logic            len_ok_s, key_last_s, key_hs_s, drop_last_s;
  logic            data_ready_s, in_hs_s, out_hs_s;
  logic [7:0]      ksi_s, kj_s, ksj_s;
  logic [7:0]      i1_s, j1_s, si_s, sj_s, k_s;

  // Keystream byte with the just-performed swap forwarded onto the lookup.
  function automatic logic [7:0] prga_out(input logic [7:0] i1, input logic [7:0] j1,
                                          input logic [7:0] si, input logic [7:0] sj,
                                          input logic [7:0] st);
    logic [7:0] t;
    t = si + sj;
    if (t == i1) prga_out = sj;
    else if (t == j1) prga_out = si;
    else prga_out = st;
  endfunction

  // Handshakes, KSA step and PRGA step computed from the current S contents.
  always_comb begin
    len_ok_s     = (KEY_LEN_IN != {KL_W{1'b0}}) && (KEY_LEN_IN <= KL_W'(MAX_KEY_BYTES));
    key_last_s   = (KL_W'(kidx_r) == (len_r - KL_W'(1)));
    key_hs_s     = KEY_VALID_IN && key_ready_r;
    drop_last_s  = (drop_r == 16'(DROP_N - 1));
    data_ready_s = (state_r == ST_PRGA) && (!dvalid_r || DATA_READY_IN);
    in_hs_s      = DATA_VALID_IN && data_ready_s;
    out_hs_s     = dvalid_r && DATA_READY_IN;
    ksi_s        = s_r[i_r];
    kj_s         = j_r + ksi_s + key_r[kidx_r];
    ksj_s        = s_r[kj_s];
    i1_s         = i_r + 8'd1;
    si_s         = s_r[i1_s];
    j1_s         = j_r + si_s;
    sj_s         = s_r[j1_s];
    k_s          = prga_out(i1_s, j1_s, si_s, sj_s, s_r[si_s + sj_s]);
  end

  // Next-state logic; STOP_IN overrides every other transition.
  always_comb begin
    state_n = state_r;
    if (STOP_IN) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:     state_n = (START_IN && len_ok_s) ? ST_KEY_LOAD : ST_IDLE;
        ST_KEY_LOAD: state_n = (key_hs_s && key_last_s) ? ST_INIT : ST_KEY_LOAD;
        ST_INIT:     state_n = (i_r == 8'd255) ? ST_KSA : ST_INIT;
        ST_KSA: begin
          if (i_r == 8'd255) state_n = (DROP_N == 0) ? ST_PRGA : ST_DROP;
          else state_n = ST_KSA;
        end
        ST_DROP:     state_n = drop_last_s ? ST_PRGA : ST_DROP;
        ST_PRGA:     state_n = ST_PRGA;
        default:     state_n = ST_IDLE;
      endcase
    end
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      key_ready_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      busy_r      <= (state_n != ST_IDLE);
      key_ready_r <= (state_n == ST_KEY_LOAD);
    end
  end

  // Datapath: key capture, S-box sweeps, drop and data stream. S is not reset.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN || STOP_IN) begin
      len_r    <= {KL_W{1'b0}};
      kidx_r   <= {KI_W{1'b0}};
      i_r      <= 8'd0;
      j_r      <= 8'd0;
      drop_r   <= 16'd0;
      err_r    <= 1'b0;
      dvalid_r <= 1'b0;
      dout_r   <= 8'd0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START_IN && len_ok_s) begin
            len_r  <= KEY_LEN_IN;
            kidx_r <= {KI_W{1'b0}};
          end else if (START_IN) begin
            err_r <= 1'b1;
          end
        end
        ST_KEY_LOAD: begin
          if (key_hs_s) begin
            key_r[kidx_r] <= KEY_BYTE_IN;
            kidx_r        <= key_last_s ? {KI_W{1'b0}} : kidx_r + KI_W'(1);
          end
        end
        ST_INIT: begin
          s_r[i_r] <= i_r;
          i_r      <= i_r + 8'd1;
        end
        ST_KSA: begin
          s_r[i_r] <= ksj_s;
          s_r[kj_s] <= ksi_s;
          i_r      <= i_r + 8'd1;
          j_r      <= (i_r == 8'd255) ? 8'd0 : kj_s;
          kidx_r   <= key_last_s ? {KI_W{1'b0}} : kidx_r + KI_W'(1);
        end
        ST_DROP: begin
          s_r[i1_s] <= sj_s;
          s_r[j1_s] <= si_s;
          i_r       <= i1_s;
          j_r       <= j1_s;
          drop_r    <= drop_r + 16'd1;
        end
        ST_PRGA: begin
          if (in_hs_s) begin
            s_r[i1_s] <= sj_s;
            s_r[j1_s] <= si_s;
            i_r       <= i1_s;
            j_r       <= j1_s;
            dout_r    <= DATA_IN ^ k_s;
            dvalid_r  <= 1'b1;
          end else if (out_hs_s) begin
            dvalid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign KEY_READY_OUT  = key_ready_r;
  assign DATA_READY_OUT = data_ready_s;
  assign DATA_VALID_OUT = dvalid_r;
  assign DATA_OUT       = dout_r;
  assign BUSY_OUT       = busy_r;
  assign ERR_OUT        = err_r;

endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed bench for rc4_stream_core: two instances (DROP_N=0 and DROP_N=3)
// share one set of inputs; expected bytes are published RC4 test vectors.
module tb_rc4_stream_core;

  logic       CLK_IN = 1'b0;
  logic       RESET_IN, START_IN, STOP_IN, KEY_VALID_IN, DATA_VALID_IN, DATA_READY_IN;
  logic [8:0] KEY_LEN_IN;
  logic [7:0] KEY_BYTE_IN, DATA_IN;
  logic       key_ready0, data_ready0, dvalid0, busy0, err0;
  logic       key_ready1, data_ready1, dvalid1, busy1, err1;
  logic [7:0] dout0, dout1;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic [7:0] din_q[$];
  logic [7:0] exp_q[$];

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  rc4_stream_core #(.MAX_KEY_BYTES(32), .DROP_N(0), .KL_W(9)) dut0 (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .START_IN(START_IN), .STOP_IN(STOP_IN),
    .KEY_LEN_IN(KEY_LEN_IN), .KEY_VALID_IN(KEY_VALID_IN), .KEY_BYTE_IN(KEY_BYTE_IN),
    .KEY_READY_OUT(key_ready0), .DATA_VALID_IN(DATA_VALID_IN), .DATA_IN(DATA_IN),
    .DATA_READY_OUT(data_ready0), .DATA_VALID_OUT(dvalid0), .DATA_OUT(dout0),
    .DATA_READY_IN(DATA_READY_IN), .BUSY_OUT(busy0), .ERR_OUT(err0));

  rc4_stream_core #(.MAX_KEY_BYTES(32), .DROP_N(3), .KL_W(9)) dut1 (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .START_IN(START_IN), .STOP_IN(STOP_IN),
    .KEY_LEN_IN(KEY_LEN_IN), .KEY_VALID_IN(KEY_VALID_IN), .KEY_BYTE_IN(KEY_BYTE_IN),
    .KEY_READY_OUT(key_ready1), .DATA_VALID_IN(DATA_VALID_IN), .DATA_IN(DATA_IN),
    .DATA_READY_OUT(data_ready1), .DATA_VALID_OUT(dvalid1), .DATA_OUT(dout1),
    .DATA_READY_IN(DATA_READY_IN), .BUSY_OUT(busy1), .ERR_OUT(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK_IN);
    chk(tag, 32'({busy0, key_ready0, dvalid0, data_ready0, err0, dout0}), 32'd0);
  endtask

  task automatic do_stop();
    tick();
    STOP_IN = 1'b1;
    tick();
    STOP_IN = 1'b0;
  endtask

  task automatic set_din(input string s);
    din_q.delete();
    for (int k = 0; k < s.len(); k++) din_q.push_back(s[k]);
  endtask

  task automatic load_key(input string k, output int hs_cyc);
    int idx = 0;
    int budget = 0;
    hs_cyc = 0;
    tick();
    START_IN = 1'b1;
    KEY_LEN_IN = 9'(k.len());
    tick();
    START_IN = 1'b0;
    while (idx < k.len() && budget < 100) begin
      KEY_VALID_IN = 1'b1;
      KEY_BYTE_IN = k[idx];
      @(negedge CLK_IN);
      if (key_ready0) begin
        idx++;
        hs_cyc = cyc + 1;
      end
      budget++;
      tick();
    end
    KEY_VALID_IN = 1'b0;
    chk("key_load_count", idx, k.len());
  endtask

  task automatic wait_ready(input int from, input int exp_lat);
    int lat = -1;
    for (int b = 0; b < 2000 && lat < 0; b++) begin
      @(negedge CLK_IN);
      if (data_ready0) lat = cyc - from;
    end
    chk("ready_latency", lat, exp_lat);
  endtask

  task automatic stream(input string tag, input bit gaps, input bit bp);
    int n = din_q.size();
    int ii = 0, oi = 0, budget = 0, first = -1, last = -1;
    bit rdy = 1'b1, stall = 1'b0;
    logic [7:0] held = 8'd0;
    while (oi < n && budget < 300) begin
      tick();
      DATA_VALID_IN = (ii < n) && (!gaps || ($urandom_range(0, 1) == 1));
      DATA_IN = (ii < n) ? din_q[ii] : 8'h00;
      DATA_READY_IN = bp ? rdy : 1'b1;
      rdy = ~rdy;
      @(negedge CLK_IN);
      if (stall) chk({tag, "_hold"}, {dvalid0, dout0}, {1'b1, held});
      stall = dvalid0 && !DATA_READY_IN;
      held = dout0;
      if (dvalid0 && DATA_READY_IN) begin
        chk({tag, "_byte"}, dout0, exp_q[oi]);
        if (first < 0) first = budget;
        last = budget;
        oi++;
      end
      if (DATA_VALID_IN && data_ready0) ii++;
      budget++;
    end
    tick();
    DATA_VALID_IN = 1'b0;
    DATA_READY_IN = 1'b1;
    chk({tag, "_count"}, oi, n);
    if (!gaps && !bp) chk({tag, "_b2b"}, last - first, n - 1);
  endtask

  initial begin
    int hs;
    int lat0, lat1;
    logic [7:0] e0 [0:2];
    logic [7:0] e1 [0:2];
    e0 = '{8'hEB, 8'h9F, 8'h77};
    e1 = '{8'h81, 8'hB7, 8'h34};
    RESET_IN = 1'b1; START_IN = 1'b0; STOP_IN = 1'b0; KEY_LEN_IN = 9'd0;
    KEY_VALID_IN = 1'b0; KEY_BYTE_IN = 8'd0; DATA_VALID_IN = 1'b0; DATA_IN = 8'd0;
    DATA_READY_IN = 1'b1;
    repeat (3) tick();
    RESET_IN = 1'b0;
    check_idle("reset_state");

    // Key / Plaintext, back-to-back
    load_key("Key", hs);
    wait_ready(hs, 512);
    set_din("Plaintext");
    exp_q = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    stream("key_pt", 1'b0, 1'b0);

    // Wiki / pedia with toggling backpressure and random input gaps
    do_stop();
    load_key("Wiki", hs);
    wait_ready(hs, 512);
    set_din("pedia");
    exp_q = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    stream("wiki", 1'b1, 1'b1);

    // Secret: encrypt, then re-key and decrypt
    do_stop();
    load_key("Secret", hs);
    wait_ready(hs, 512);
    set_din("Attack at dawn");
    exp_q = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
              8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    stream("secret_enc", 1'b0, 1'b0);
    do_stop();
    load_key("Secret", hs);
    wait_ready(hs, 512);
    din_q = exp_q;
    exp_q.delete();
    begin
      string pt = "Attack at dawn";
      for (int k = 0; k < pt.len(); k++) exp_q.push_back(pt[k]);
    end
    stream("secret_dec", 1'b0, 1'b0);

    // DROP_N=3 instance against DROP_N=0 instance on a zero stream
    do_stop();
    load_key("Key", hs);
    lat0 = -1;
    lat1 = -1;
    for (int b = 0; b < 2000 && lat1 < 0; b++) begin
      @(negedge CLK_IN);
      if (data_ready0 && lat0 < 0) lat0 = cyc - hs;
      if (data_ready1 && lat1 < 0) lat1 = cyc - hs;
    end
    chk("drop0_latency", lat0, 512);
    chk("drop3_latency", lat1, 515);
    for (int k = 0; k < 4; k++) begin
      tick();
      DATA_VALID_IN = (k < 3);
      DATA_IN = 8'h00;
      @(negedge CLK_IN);
      if (k > 0) begin
        chk("drop3_byte", {dvalid1, dout1}, {1'b1, e1[k-1]});
        chk("drop0_byte", {dvalid0, dout0}, {1'b1, e0[k-1]});
      end
    end
    tick();
    DATA_VALID_IN = 1'b0;

    // Rejected key lengths, then a maximum-length key
    do_stop();
    tick();
    START_IN = 1'b1;
    KEY_LEN_IN = 9'd0;
    tick();
    START_IN = 1'b0;
    @(negedge CLK_IN);
    chk("err_len0", {err0, busy0}, 2'b10);
    tick();
    @(negedge CLK_IN);
    chk("err_len0_pulse", {err0, busy0}, 2'b00);
    tick();
    START_IN = 1'b1;
    KEY_LEN_IN = 9'd33;
    tick();
    START_IN = 1'b0;
    @(negedge CLK_IN);
    chk("err_len33", {err0, busy0}, 2'b10);
    tick();
    @(negedge CLK_IN);
    chk("err_len33_pulse", {err0, busy0}, 2'b00);
    load_key("0123456789abcdefghijklmnopqrstuv", hs);
    @(negedge CLK_IN);
    chk("maxkey_init", {busy0, key_ready0, err0}, 3'b100);

    // STOP mid-KSA
    do_stop();
    load_key("Key", hs);
    repeat (300) tick();
    STOP_IN = 1'b1;
    tick();
    STOP_IN = 1'b0;
    check_idle("stop_ksa");

    // STOP in PRGA with an output byte pending
    load_key("Key", hs);
    wait_ready(hs, 512);
    tick();
    DATA_READY_IN = 1'b0;
    DATA_VALID_IN = 1'b1;
    DATA_IN = 8'h50;
    tick();
    DATA_VALID_IN = 1'b0;
    @(negedge CLK_IN);
    chk("pending_byte", {dvalid0, dout0}, {1'b1, 8'hBB});
    tick();
    STOP_IN = 1'b1;
    tick();
    STOP_IN = 1'b0;
    DATA_READY_IN = 1'b1;
    check_idle("stop_prga");

    // Re-key after STOP reproduces the first vector
    load_key("Key", hs);
    wait_ready(hs, 512);
    set_din("Plaintext");
    exp_q = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    stream("rekey_pt", 1'b0, 1'b0);

    // START alongside STOP, then alongside RESET, from IDLE
    do_stop();
    tick();
    STOP_IN = 1'b1;
    START_IN = 1'b1;
    KEY_LEN_IN = 9'd3;
    tick();
    STOP_IN = 1'b0;
    START_IN = 1'b0;
    check_idle("stop_start");
    tick();
    RESET_IN = 1'b1;
    START_IN = 1'b1;
    tick();
    RESET_IN = 1'b0;
    START_IN = 1'b0;
    check_idle("reset_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
